// File: rtl/heq_pkg.sv
// Shared constants and FSM encoding for the histogram-equalisation blocks.
// The CDF builder and its divider both pull their sizing from here.
package heq_pkg;

  localparam int          NUM_BINS    = 256;
  localparam logic [15:0] TAG_HIST    = 16'hAAAA;
  localparam logic [15:0] TAG_LUT     = 16'hBBBB;
  localparam logic [15:0] LUT_BASE    = 16'd256;

  // Two extra SCAN cycles drain the read-latency / accumulate pipeline.
  localparam int          SCAN_DRAIN  = 2;
  localparam int          DIV_LATENCY = 24;
  localparam int          MAP_SLOT    = 27;

  // The m3 read port is parked here during SCAN so it never aliases a write.
  localparam logic [15:0] PARK_ADDR   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_MAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// 24-bit by 16-bit restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so the quotient is final 24 cycles after start.
module seq_divider (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] numerator,
  input  logic [15:0] denominator,
  output logic        busy,
  output logic [23:0] quotient
);
  import heq_pkg::*;

  logic [15:0] rem;
  logic [15:0] den_q;
  logic [23:0] dq;
  logic [4:0]  steps_left;

  // dq holds unconsumed dividend bits at the top and quotient bits shifting in below.
  function automatic logic [39:0] div_step(input logic [15:0] r,
                                           input logic [23:0] q,
                                           input logic [15:0] d);
    logic [16:0] shifted;
    logic        ge;
    logic [15:0] rem_new;
    shifted = {r, q[23]};
    ge      = shifted >= {1'b0, d};
    rem_new = ge ? (shifted[15:0] - d) : shifted[15:0];
    return {rem_new, q[22:0], ge};
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= '0;
      den_q      <= '0;
      dq         <= '0;
      steps_left <= '0;
      busy       <= 1'b0;
    end else if (start) begin
      {rem, dq}  <= div_step(16'd0, numerator, denominator);
      den_q      <= denominator;
      steps_left <= 5'(DIV_LATENCY - 1);
      busy       <= 1'b1;
    end else if (busy) begin
      {rem, dq}  <= div_step(rem, dq, den_q);
      steps_left <= steps_left - 5'd1;
      if (steps_left == 5'd1) begin
        busy <= 1'b0;
      end
    end
  end

  assign quotient = dq;

endmodule

// File: rtl/cdf_lut_builder.sv
// Builds the cumulative histogram into m3[0..255] and the equalisation LUT into m3[256..511].
// SCAN streams the histogram once; MAP then spends a fixed 27-cycle slot per pixel value.
module cdf_lut_builder #(
  parameter int          NUM_BINS = heq_pkg::NUM_BINS,
  parameter logic [15:0] TAG_HIST = heq_pkg::TAG_HIST,
  parameter logic [15:0] TAG_LUT  = heq_pkg::TAG_LUT
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  output logic [15:0]  m2ReadAddr,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         m3WE,
  output logic [15:0]  m3ReadAddr,
  input  logic [127:0] m3ReadVal,
  output logic         done
);
  import heq_pkg::*;

  localparam logic [15:0] LAST_BIN     = 16'(NUM_BINS - 1);
  localparam logic [15:0] SCAN_LAST    = 16'(NUM_BINS + SCAN_DRAIN - 1);
  localparam logic [4:0]  PH_DIV_START = 5'd1;
  localparam logic [4:0]  PH_LOAD      = 5'(DIV_LATENCY + 1);
  localparam logic [4:0]  SLOT_LAST    = 5'(MAP_SLOT - 1);

  state_t      state;
  state_t      state_next;

  logic [15:0] scan_cnt;
  logic [15:0] map_v;
  logic [4:0]  phase;
  logic [15:0] sum;
  logic [15:0] cdf_min;
  logic        min_found;
  logic        lut_zero;

  logic        start_accept;
  logic        scan_capture;
  logic        scan_end;
  logic        div_start;
  logic        lut_load;
  logic        slot_end;
  logic        map_last;

  logic [15:0] bin_count;
  logic [15:0] sum_next;
  logic [15:0] cdf_v;
  logic [15:0] den;
  logic [23:0] num;
  logic [23:0] quotient;
  logic        div_busy;
  logic        unused_bits;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_accept) state_next = ST_SCAN;
      ST_SCAN:          if (scan_end)     state_next = ST_MAP;
      ST_MAP:           if (map_last)     state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Cycle-level strobes decoded from the state and the SCAN / MAP counters.
  always_comb begin
    start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    scan_capture = (state == ST_SCAN) && (scan_cnt != 16'd0) &&
                   (scan_cnt <= 16'(NUM_BINS));
    scan_end     = (state == ST_SCAN) && (scan_cnt == SCAN_LAST);
    div_start    = (state == ST_MAP) && (phase == PH_DIV_START);
    lut_load     = (state == ST_MAP) && (phase == PH_LOAD);
    slot_end     = (state == ST_MAP) && (phase == SLOT_LAST);
    map_last     = slot_end && (map_v == LAST_BIN);
  end

  always_comb begin
    bin_count = (m2ReadVal[31:16] == TAG_HIST) ? m2ReadVal[15:0] : 16'd0;
    sum_next  = sum + bin_count;
    cdf_v     = m3ReadVal[15:0];
    den       = sum - cdf_min;
    num       = {8'd0, 16'(cdf_v - cdf_min)} * 24'd255;
  end

  seq_divider u_div (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (div_start),
    .numerator   (num),
    .denominator (den),
    .busy        (div_busy),
    .quotient    (quotient)
  );

  // A CDF word lands two cycles after its histogram address went out.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      map_v       <= '0;
      phase       <= '0;
      sum         <= '0;
      cdf_min     <= '0;
      min_found   <= 1'b0;
      lut_zero    <= 1'b0;
      m2ReadAddr  <= '0;
      m3ReadAddr  <= '0;
      m3WriteAddr <= '0;
      m3WriteVal  <= '0;
      m3WE        <= 1'b0;
    end else begin
      m3WE <= 1'b0;
      if (start_accept) begin
        sum        <= '0;
        cdf_min    <= '0;
        min_found  <= 1'b0;
        scan_cnt   <= '0;
        m2ReadAddr <= '0;
        m3ReadAddr <= PARK_ADDR;
      end
      if (state == ST_SCAN) begin
        scan_cnt <= scan_cnt + 16'd1;
        if (scan_cnt < LAST_BIN) begin
          m2ReadAddr <= scan_cnt + 16'd1;
        end
        if (scan_capture) begin
          sum         <= sum_next;
          m3WE        <= 1'b1;
          m3WriteAddr <= scan_cnt - 16'd1;
          m3WriteVal  <= {96'd0, TAG_HIST, sum_next};
          if (!min_found && (sum_next != 16'd0)) begin
            cdf_min   <= sum_next;
            min_found <= 1'b1;
          end
        end
        if (scan_end) begin
          map_v      <= '0;
          phase      <= '0;
          m3ReadAddr <= '0;
        end
      end
      if (state == ST_MAP) begin
        phase <= phase + 5'd1;
        if (div_start) begin
          lut_zero <= !min_found || (cdf_v <= cdf_min) || (den == 16'd0);
        end
        if (lut_load) begin
          m3WE        <= 1'b1;
          m3WriteAddr <= LUT_BASE + map_v;
          m3WriteVal  <= {96'd0, TAG_LUT, 8'd0, (lut_zero ? 8'd0 : quotient[7:0])};
        end
        if (slot_end) begin
          phase      <= '0;
          map_v      <= map_v + 16'd1;
          m3ReadAddr <= map_v + 16'd1;
        end
      end
    end
  end

  // done rises one cycle after DONE is entered and drops on the accepting edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (start_accept) begin
      done <= 1'b0;
    end else if (state == ST_DONE) begin
      done <= 1'b1;
    end
  end

  assign unused_bits = ^{m2ReadVal[127:32], m3ReadVal[127:16], quotient[23:8], div_busy};

endmodule

// File: tb/tb_cdf_lut_builder.sv
// Self-checking bench for cdf_lut_builder: scratchpad models, a plain-arithmetic CDF/LUT
// model and a per-cycle compare process keyed on cycles since the accepting start edge.
module tb_cdf_lut_builder;

  localparam logic [15:0] TAG_H      = 16'hAAAA;
  localparam logic [15:0] TAG_L      = 16'hBBBB;
  localparam int          MAP_START  = 258;
  localparam int          SLOT       = 27;
  localparam int          MAP_END    = MAP_START + 256 * SLOT;
  localparam int          DONE_CYCLE = 1 + 258 + 256 * 27;
  localparam int          RUN_CYCLES = DONE_CYCLE + 5;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  m2ReadAddr;
  logic [127:0] m2ReadVal = '0;
  logic [15:0]  m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic         m3WE;
  logic [15:0]  m3ReadAddr;
  logic [127:0] m3ReadVal = '0;
  logic         done;

  logic [127:0] m2_mem [0:255];
  logic [127:0] m3_mem [0:511];

  int hist_tag [256];
  int hist_cnt [256];
  int exp_cdf  [256];
  int exp_lut  [256];
  int exp_min;
  int exp_total;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;
  int t0           = 0;
  int done_rise    = -1;
  bit active       = 1'b0;

  cdf_lut_builder dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .m2ReadAddr  (m2ReadAddr),
    .m2ReadVal   (m2ReadVal),
    .m3WriteAddr (m3WriteAddr),
    .m3WriteVal  (m3WriteVal),
    .m3WE        (m3WE),
    .m3ReadAddr  (m3ReadAddr),
    .m3ReadVal   (m3ReadVal),
    .done        (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Both scratchpads return data one cycle after the address.
  always @(posedge clock) begin
    m2ReadVal <= (m2ReadAddr < 16'd256) ? m2_mem[m2ReadAddr[7:0]] : '0;
    m3ReadVal <= (m3ReadAddr < 16'd512) ? m3_mem[m3ReadAddr[8:0]] : '0;
    if (m3WE && (m3WriteAddr < 16'd512)) m3_mem[m3WriteAddr[8:0]] <= m3WriteVal;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic clear_hist();
    for (int v = 0; v < 256; v++) begin
      hist_tag[v] = 0;
      hist_cnt[v] = 0;
    end
  endtask

  task automatic set_bin(input int v, input int tag, input int cnt);
    hist_tag[v] = tag;
    hist_cnt[v] = cnt;
  endtask

  task automatic compute_model();
    int s;
    bit found;
    s = 0;
    found = 1'b0;
    exp_min = 0;
    for (int v = 0; v < 256; v++) begin
      if (hist_tag[v] == int'(TAG_H)) s += hist_cnt[v];
      exp_cdf[v] = s % 65536;
      if (!found && exp_cdf[v] != 0) begin
        found = 1'b1;
        exp_min = exp_cdf[v];
      end
    end
    exp_total = exp_cdf[255];
    for (int v = 0; v < 256; v++) begin
      if (found && exp_cdf[v] > exp_min && exp_total != exp_min)
        exp_lut[v] = ((exp_cdf[v] - exp_min) * 255) / (exp_total - exp_min);
      else
        exp_lut[v] = 0;
    end
  endtask

  task automatic load_m2();
    for (int v = 0; v < 256; v++) begin
      m2_mem[v] = {$urandom, $urandom, $urandom, 16'(hist_tag[v]), 16'(hist_cnt[v])};
    end
  endtask

  // Runs one full build; optionally pulses start again mid-SCAN, which must be ignored.
  task automatic applyStimulus(input bit pulse_mid);
    load_m2();
    compute_model();
    @(negedge clock);
    start = 1'b1;
    done_rise = -1;
    t0 = edge_cnt + 1;
    active = 1'b1;
    for (int i = 0; i <= RUN_CYCLES; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      if (pulse_mid && i == 50) start = 1'b1;
      if (pulse_mid && i == 51) start = 1'b0;
    end
    active = 1'b0;
    checkOutput("done_latency", 128'(done_rise), 128'(DONE_CYCLE));
  endtask

  always @(negedge clock) begin : compare
    int k;
    int v;
    bit exp_we;
    if (active) begin
      k = edge_cnt - t0;
      if (k >= 0) begin
        if (k <= 255) checkOutput("m2_addr", m2ReadAddr, 128'(k));
        exp_we = (k >= 2 && k <= 257) ||
                 (k >= MAP_START && k < MAP_END && ((k - MAP_START) % SLOT) == SLOT - 1);
        checkOutput("m3_we", m3WE, exp_we);
        if (exp_we && m3WE) begin
          if (k <= 257) begin
            v = k - 2;
            checkOutput("cdf_addr", m3WriteAddr, 128'(v));
            checkOutput("cdf_word", m3WriteVal, {96'd0, TAG_H, 16'(exp_cdf[v])});
          end else begin
            v = (k - MAP_START) / SLOT;
            checkOutput("lut_addr", m3WriteAddr, 128'(256 + v));
            checkOutput("lut_word", m3WriteVal, {96'd0, TAG_L, 8'd0, 8'(exp_lut[v])});
          end
        end
        if (m3WE) checkOutput("rw_distinct", (m3WriteAddr != m3ReadAddr), 1'b1);
        if (k >= MAP_START && k < MAP_END && ((k - MAP_START) % SLOT) == 0)
          checkOutput("m3_raddr", m3ReadAddr, 128'((k - MAP_START) / SLOT));
        checkOutput("done", done, (k >= DONE_CYCLE));
        if (done && done_rise < 0) done_rise = k;
      end
    end
  end

  initial begin
    int nz;
    #1;
    checkOutput("rst_m2_addr", m2ReadAddr, 0);
    checkOutput("rst_m3_waddr", m3WriteAddr, 0);
    checkOutput("rst_m3_wval", m3WriteVal, 0);
    checkOutput("rst_m3_we", m3WE, 0);
    checkOutput("rst_m3_raddr", m3ReadAddr, 0);
    checkOutput("rst_done", done, 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("idle_we", m3WE, 0);
      checkOutput("idle_done", done, 0);
    end

    // Single bin 5 = 64: flat CDF, every LUT entry zero.
    clear_hist();
    set_bin(5, TAG_H, 64);
    applyStimulus(1'b0);
    checkOutput("t31_model_min", 128'(exp_min), 128'(64));
    checkOutput("t31_cdf4", m3_mem[4][15:0], 16'd0);
    checkOutput("t31_cdf5", m3_mem[5][15:0], 16'd64);
    checkOutput("t31_cdf255", m3_mem[255][15:0], 16'd64);
    nz = 0;
    for (int v = 0; v < 256; v++) if (m3_mem[256 + v][7:0] != 8'd0) nz++;
    checkOutput("t31_lut_nonzero", 128'(nz), 128'(0));
    checkOutput("t31_lut_tag", m3_mem[300][31:16], TAG_L);
    checkOutput("t31_done", done, 1'b1);

    // Bins 0 and 255 = 32; restarted straight from DONE.
    clear_hist();
    set_bin(0, TAG_H, 32);
    set_bin(255, TAG_H, 32);
    applyStimulus(1'b0);
    checkOutput("t32_model_min", 128'(exp_min), 128'(32));
    checkOutput("t32_lut0", m3_mem[256][7:0], 8'd0);
    checkOutput("t32_lut254", m3_mem[510][7:0], 8'd0);
    checkOutput("t32_lut255", m3_mem[511][7:0], 8'd255);

    // Four equal bins: LUT steps 0, 85, 170, 255.
    clear_hist();
    set_bin(10, TAG_H, 16);
    set_bin(20, TAG_H, 16);
    set_bin(30, TAG_H, 16);
    set_bin(40, TAG_H, 16);
    applyStimulus(1'b0);
    checkOutput("t33_lut10", m3_mem[266][7:0], 8'd0);
    checkOutput("t33_lut20", m3_mem[276][7:0], 8'd85);
    checkOutput("t33_lut30", m3_mem[286][7:0], 8'd170);
    checkOutput("t33_lut40", m3_mem[296][7:0], 8'd255);
    checkOutput("t33_lut200", m3_mem[456][7:0], 8'd255);

    // Untagged bin 7 contributes nothing.
    clear_hist();
    set_bin(3, TAG_H, 5);
    set_bin(7, 0, 9);
    set_bin(9, TAG_H, 4);
    applyStimulus(1'b0);
    checkOutput("t34_cdf6", m3_mem[6][15:0], 16'd5);
    checkOutput("t34_cdf7", m3_mem[7][15:0], 16'd5);
    checkOutput("t34_cdf9", m3_mem[9][15:0], 16'd9);

    // Dense random histogram with some stale tags, plus an ignored mid-SCAN start.
    for (int v = 0; v < 256; v++) begin
      if ($urandom_range(0, 7) == 0) begin
        hist_tag[v] = int'($urandom_range(0, 65535));
        if (hist_tag[v] == int'(TAG_H)) hist_tag[v] = 16'h1234;
      end else begin
        hist_tag[v] = int'(TAG_H);
      end
      hist_cnt[v] = int'($urandom_range(0, 255));
    end
    applyStimulus(1'b1);

    // Abort at SCAN cycle 100, then rebuild the same histogram.
    @(negedge clock);
    start = 1'b1;
    done_rise = -1;
    t0 = edge_cnt + 1;
    active = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (100) @(negedge clock);
    active = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_m2_addr", m2ReadAddr, 0);
    checkOutput("abort_m3_waddr", m3WriteAddr, 0);
    checkOutput("abort_m3_wval", m3WriteVal, 0);
    checkOutput("abort_m3_we", m3WE, 0);
    checkOutput("abort_m3_raddr", m3ReadAddr, 0);
    checkOutput("abort_done", done, 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checkOutput("post_abort_we", m3WE, 0);
      checkOutput("post_abort_m2", m2ReadAddr, 0);
      checkOutput("post_abort_done", done, 0);
    end
    applyStimulus(1'b0);

    // Sparse random histogram with large counts.
    clear_hist();
    for (int i = 0; i < 6; i++) begin
      set_bin(int'($urandom_range(0, 255)), TAG_H, int'($urandom_range(0, 2000)));
    end
    applyStimulus(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
